encoder: RTL and testbench
==========================

ENCODER -- requirements
Module: encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of request input bits; legal values are powers of two, 2 to 256.
REQ-002 SHALL have parameter OUT_W, default $clog2(WIDTH): width of the encoded index; derived, never overridden independently.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in, input, WIDTH bits: request vector; bit i set means index i is requested.
REQ-006 SHALL have port out, output, OUT_W bits: registered binary index of the selected request bit.
REQ-007 SHALL have port valid, output, 1 bit: registered; high when the sampled in had at least one bit set.
REQ-008 SHALL have port err, output, 1 bit, present only when ENCODER_ONEHOT_CHECK_EN is defined: registered multi-hot flag.

Function
REQ-009 SHALL sample in on every rising clk edge when rst is low and update out, valid (and err) on that same edge; latency exactly 1 cycle, throughput one vector per cycle.
REQ-010 SHALL encode one-hot in to its bit index: 0001->00, 0010->01, 0100->10, 1000->11 for WIDTH=4.
REQ-011 SHALL apply highest-index priority when more than one bit is set: out = index of the most significant set bit (e.g. 0110->10, 1111->11).
REQ-012 SHALL drive out=0 and valid=0 when sampled in is all zeros.
REQ-013 SHALL set valid=1 for any non-zero sampled in, one-hot or not.
REQ-014 SHALL have no enable and no hold: every non-reset edge overwrites out/valid/err with values derived from the current in.
REQ-015 SHALL contain no combinational path from in to any output; all outputs are driven directly from flops.
REQ-016 SHALL treat X/Z on in as don't-care; no requirement on the resulting output values.

Reset
REQ-017 SHALL, on a rising clk edge with rst=1, set out=0, valid=0, and err=0 (if present), regardless of in.
REQ-018 SHALL give rst priority over in on the same edge; the in value present during that edge is discarded, never delayed or queued.
REQ-019 SHALL resume normal encoding on the first rising edge with rst=0, producing the result for in sampled on that edge.
REQ-020 SHALL leave outputs undefined before the first reset edge; users apply reset before relying on outputs.

Configuration
REQ-021 SHALL use macro ENCODER_ONEHOT_CHECK_EN to compile in the one-hot checker.
REQ-022 With ENCODER_ONEHOT_CHECK_EN defined: port err exists; it registers 1 when the sampled in has two or more bits set, and 0 for zero or exactly one bit set; out/valid behaviour is unchanged.
REQ-023 With ENCODER_ONEHOT_CHECK_EN undefined: port err and all checker logic are absent; all other behaviour is identical.

Verification
REQ-024 Bench SHALL cover reset: rst=1 for 2 edges with in=1000 -> out=00, valid=0, err=0; first edge after rst=0 with in=1000 -> out=11, valid=1.
REQ-025 Bench SHALL cover the one-hot sweep: in=0001,0010,0100,1000 on consecutive edges -> out=00,01,10,11 each one cycle later, valid=1, err=0.
REQ-026 Bench SHALL cover zero input: in=0000 -> out=00, valid=0, err=0 one cycle later.
REQ-027 Bench SHALL cover priority: in=0110 -> out=10; in=1111 -> out=11; in=0011 -> out=01; all valid=1 and, with ENCODER_ONEHOT_CHECK_EN, err=1.
REQ-028 Bench SHALL cover reset mid-stream: in=0100 with rst asserted on one edge -> out=00, valid=0 on that edge; next edge with rst=0 -> out=10, valid=1.
REQ-029 Bench SHALL cover exhaustive sweep: all 16 values of in for WIDTH=4, checking out, valid, and err one cycle later against a priority-encoder model, built both with and without ENCODER_ONEHOT_CHECK_EN.

Source files
------------

// File: rtl/encoder.sv
// Registered highest-index-priority encoder: WIDTH request bits to OUT_W index.
// Ports: clk, rst (sync, active-high), in[WIDTH], out[OUT_W], valid, err (multi-hot,
// only when ENCODER_ONEHOT_CHECK_EN is defined). All outputs come straight from flops.
module encoder #(
  parameter int WIDTH = 4,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid
`ifdef ENCODER_ONEHOT_CHECK_EN
  ,
  output logic             err
`endif
);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;

  // Ascending scan: a later (higher) set bit overrides, giving MSB priority.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) w_idx = OUT_W'(i);
    end
  end

  assign w_any = |in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_idx;
      r_valid <= w_any;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic w_multi;
  logic r_err;

  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign w_multi = |(in & (in - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_multi;
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_encoder.sv
// Directed-vector bench for encoder (WIDTH=4).
// Table of {rst, in, expected out/valid/err}, a discard check and a 16-value sweep.
module tb_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [1:0] out;
  logic       valid;
  logic       err_s;
  int checks;
  int failures;

  typedef struct {
    logic       rst;
    logic [3:0] in;
    logic [1:0] e_out;
    logic       e_valid;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic err;
  assign err_s = err;
  encoder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in(in),
    .out(out), .valid(valid), .err(err)
  );
`else
  assign err_s = 1'b0;
  encoder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in(in),
    .out(out), .valid(valid)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic r, input logic [3:0] v);
    rst = r;
    in  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] eo,
                     input logic ev, input logic ee);
    checks++;
    if (out !== eo || valid !== ev) begin
      failures++;
      $display("FAIL %s: got out=%b valid=%b, want out=%b valid=%b",
               nm, out, valid, eo, ev);
    end
`ifdef ENCODER_ONEHOT_CHECK_EN
    checks++;
    if (err !== ee) begin
      failures++;
      $display("FAIL %s: got err=%b, want err=%b", nm, err, ee);
    end
`else
    if (ee && err_s) $display("note: unreachable");
`endif
  endtask

  function automatic logic [1:0] model_idx(input logic [3:0] v);
    for (int i = 3; i >= 0; i--)
      if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in  = 4'b1000;

    vecs.push_back('{1'b1, 4'b1000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b1000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b1000, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b1000, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0110, 2'd2, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 2'd3, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 2'd1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 4'b0100, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].in);
      chk($sformatf("vec%0d_in%b", k, vecs[k].in),
          vecs[k].e_out, vecs[k].e_valid, vecs[k].e_err);
    end

    // Multi-hot value present during reset must be dropped, not delayed.
    step(1'b0, 4'b1111);
    chk("pre_rst_multi", 2'd3, 1'b1, 1'b1);
    step(1'b1, 4'b1111);
    chk("rst_discard", 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0000);
    chk("post_rst_zero", 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0001);
    chk("post_rst_one", 2'd0, 1'b1, 1'b0);

    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv = 4'(v);
      step(1'b0, vv);
      chk($sformatf("sweep_%b", vv), model_idx(vv), vv != 4'b0,
          $countones(vv) > 1);
    end

    // Sweep in descending order so each edge overwrites a different prior value.
    for (int v = 15; v >= 0; v--) begin
      logic [3:0] vv;
      vv = 4'(v);
      step(1'b0, vv);
      chk($sformatf("rsweep_%b", vv), model_idx(vv), vv != 4'b0,
          $countones(vv) > 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
